lambert_shade_stream: RTL

// - Shading stage directly downstream of the surface-vector stage.
// - Consumes unit surface normal N, unit light vector L, hit flag and object select.
// - Computes ambient + Lambert diffuse intensity and scales the selected object colour.
// - Emits 24-bit RGB pixels on a ready/valid video stream with end-of-line (last) and start-of-frame (user) markers.
// - Credit-based in_ready lets the upstream ray-march scheduler stall issue.

---
 rtl/lambert_shade_stream_if.sv | 25 ++
 rtl/lambert_shade_stream.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lambert_shade_stream_if.sv
// Stream bundle around the Lambert shading stage: shading beats in, RGB pixels out.
// slave is the shading stage; master is the upstream scheduler together with the pixel sink.
interface lambert_shade_stream_if;
    logic        valid_in;
    logic        in_ready;
    logic        hit_in;
    logic        obj_sel;
    logic [95:0] surface_normal;
    logic [95:0] light_vec;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_pixel;
    logic        out_last;
    logic        out_user;

    modport master (
        output valid_in, hit_in, obj_sel, surface_normal, light_vec, out_ready,
        input  in_ready, out_valid, out_pixel, out_last, out_user
    );

    modport slave (
        input  valid_in, hit_in, obj_sel, surface_normal, light_vec, out_ready,
        output in_ready, out_valid, out_pixel, out_last, out_user
    );
endinterface

// File: rtl/lambert_shade_stream.sv
// Ambient + Lambert diffuse shading of a hit surface into a 24-bit RGB video stream.
// Define SHADE_HALF_LAMBERT_EN for wrapped (half-Lambert) diffuse lighting.
module lambert_shade_stream #(
    parameter int unsigned       IMG_W      = 320,
    parameter int unsigned       IMG_H      = 240,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic signed [31:0] AMBIENT   = 32'sh00200000,
    parameter logic [23:0]       COLOR0     = 24'hFF8000,
    parameter logic [23:0]       COLOR1     = 24'h40C0FF,
    parameter logic [23:0]       BG_COLOR   = 24'h000000
) (
    input  logic                         clk,
    input  logic                         rst,
    lambert_shade_stream_if.slave        bus,
    input  logic                         frame_rst,
    output logic                         overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic signed [31:0] ONE       = 32'sh01000000;
    localparam logic signed [31:0] ONE_M_AMB = ONE - AMBIENT;

    logic                rdy_en;
    logic                accept;
    logic [1:0]          occ;
    logic [CW:0]         used;

    logic signed [31:0]  nx, ny, nz, lx, ly, lz;
    logic signed [65:0]  dot;
    logic                s1_v, s1_hit, s1_obj;
    logic signed [31:0]  s1_d;

    logic signed [31:0]  diff;
    logic signed [63:0]  scaled;
    logic signed [63:0]  i_raw;
    logic [24:0]         i_next;
    logic                s2_v, s2_hit, s2_obj;
    logic [24:0]         s2_i;

    logic [23:0]         col;
    logic [23:0]         pix_next;
    logic                s3_v;
    logic [23:0]         s3_pix;

    logic [23:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic                push, pop;
    logic [XW-1:0]       x_cnt;
    logic [YW-1:0]       y_cnt;

    // Every beat in the pipe already owns a FIFO slot, so the FIFO can never overrun.
    assign occ          = 2'(s1_v) + 2'(s2_v) + 2'(s3_v);
    assign used         = (CW+1)'(count) + (CW+1)'(occ);
    assign bus.in_ready = rdy_en && (used < (CW+1)'(FIFO_DEPTH));
    assign accept       = bus.valid_in && bus.in_ready;

    assign nx = bus.surface_normal[95:64];
    assign ny = bus.surface_normal[63:32];
    assign nz = bus.surface_normal[31:0];
    assign lx = bus.light_vec[95:64];
    assign ly = bus.light_vec[63:32];
    assign lz = bus.light_vec[31:0];

    always_comb begin
        dot = 66'(nx) * 66'(lx) + 66'(ny) * 66'(ly) + 66'(nz) * 66'(lz);
    end

`ifdef SHADE_HALF_LAMBERT_EN
    logic signed [32:0] half;
`endif

    always_comb begin
        diff = '0;
`ifdef SHADE_HALF_LAMBERT_EN
        half = 33'(s1_d >>> 1) + 33'sh000800000;
        if (half < 0)
            diff = '0;
        else if (half > 33'(ONE))
            diff = ONE;
        else
            diff = 32'(half);
`else
        if (!s1_d[31])
            diff = s1_d;
`endif
        scaled = (64'(ONE_M_AMB) * 64'(diff)) >>> 24;
        i_raw  = 64'(AMBIENT) + scaled;
        if (i_raw < 0)
            i_next = '0;
        else if (i_raw > 64'(ONE))
            i_next = 25'h1000000;
        else
            i_next = 25'(i_raw);
    end

    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [24:0] i);
        logic [32:0] p;
        p = (33'(c) * 33'(i)) >> 24;
        return (p > 33'd255) ? 8'hFF : 8'(p);
    endfunction

    always_comb begin
        col      = s2_obj ? COLOR1 : COLOR0;
        pix_next = BG_COLOR;
        if (s2_hit)
            pix_next = {scale_ch(col[23:16], s2_i), scale_ch(col[15:8], s2_i), scale_ch(col[7:0], s2_i)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en   <= 1'b0;
            overflow <= 1'b0;
            s1_v     <= 1'b0;
            s1_hit   <= 1'b0;
            s1_obj   <= 1'b0;
            s1_d     <= '0;
            s2_v     <= 1'b0;
            s2_hit   <= 1'b0;
            s2_obj   <= 1'b0;
            s2_i     <= '0;
            s3_v     <= 1'b0;
            s3_pix   <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (bus.valid_in && !bus.in_ready)
                overflow <= 1'b1;
            s1_v   <= accept;
            s1_hit <= bus.hit_in;
            s1_obj <= bus.obj_sel;
            s1_d   <= 32'(dot >>> 24);
            s2_v   <= s1_v;
            s2_hit <= s1_hit;
            s2_obj <= s1_obj;
            s2_i   <= i_next;
            s3_v   <= s2_v;
            s3_pix <= pix_next;
        end
    end

    assign push          = s3_v;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_valid = (count != '0);
    assign bus.out_pixel = mem[rd_ptr];
    assign bus.out_last  = bus.out_valid && (x_cnt == XW'(IMG_W - 1));
    assign bus.out_user  = bus.out_valid && (x_cnt == '0) && (y_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s3_pix;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Raster position of the head pixel; frame_rst overrides a coincident advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (frame_rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pop) begin
            if (x_cnt == XW'(IMG_W - 1)) begin
                x_cnt <= '0;
                if (y_cnt == YW'(IMG_H - 1))
                    y_cnt <= '0;
                else
                    y_cnt <= y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end
endmodule
